// File: rtl/wave_capture.sv
// wave_capture: records a mono PCM stream into byte-wide RAM as a complete RIFF/WAVE image.
// Define WAVE_CAPTURE_16BIT_EN for 16-bit signed samples; otherwise 8-bit unsigned samples.
module wave_capture #(
  parameter int unsigned SAMPLE_RATE = 11025,
  parameter logic [15:0] MAX_DATA    = 16'd65000
) (
  input  logic        I_CLK,
  input  logic        I_RSTn,
  input  logic        I_START,
  input  logic        I_STOP,
  input  logic [15:0] I_BASE_ADDR,
  input  logic        I_SMPL_STB,
  input  logic [15:0] I_SMPL,
  output logic [15:0] O_WR_ADDR,
  output logic [7:0]  O_WR_DATA,
  output logic        O_WR_EN,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic [15:0] O_LEN,
  output logic        O_OVF
);

`ifdef WAVE_CAPTURE_16BIT_EN
  localparam int unsigned BYTES = 2;
`else
  localparam int unsigned BYTES = 1;
`endif

  localparam logic [31:0] RATE_W      = 32'(SAMPLE_RATE);
  localparam logic [31:0] BYTE_RATE_W = 32'(SAMPLE_RATE * BYTES);
  localparam logic [7:0]  BLOCK_ALIGN = 8'(BYTES);
  localparam logic [7:0]  BITS_SMPL   = 8'(8 * BYTES);
  localparam logic [5:0]  HDR_LAST    = 6'd43;
  localparam logic [15:0] DATA_OFS    = 16'd44;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_PATCH} state_t;

  state_t      state_q, state_d;
  logic        start_prev_q, start_prev_d;
  logic [15:0] base_q, base_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        hold_tail_q, hold_tail_d;
  logic        stop_seen_q, stop_seen_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] len_q, len_d;
  logic        ovf_q, ovf_d;

  logic        start_edge;
  logic        occupied;
  logic        room;
  logic [31:0] riff_size;
  logic [31:0] data_size;
  logic [2:0]  pnext;

  function automatic logic [7:0] hdr_byte(input logic [5:0] ofs);
    logic [7:0] b;
    b = 8'h00;
    case (ofs)
      6'd0:  b = 8'h52;
      6'd1:  b = 8'h49;
      6'd2:  b = 8'h46;
      6'd3:  b = 8'h46;
      6'd8:  b = 8'h57;
      6'd9:  b = 8'h41;
      6'd10: b = 8'h56;
      6'd11: b = 8'h45;
      6'd12: b = 8'h66;
      6'd13: b = 8'h6D;
      6'd14: b = 8'h74;
      6'd15: b = 8'h20;
      6'd16: b = 8'h10;
      6'd20: b = 8'h01;
      6'd22: b = 8'h01;
      6'd24: b = RATE_W[7:0];
      6'd25: b = RATE_W[15:8];
      6'd26: b = RATE_W[23:16];
      6'd27: b = RATE_W[31:24];
      6'd28: b = BYTE_RATE_W[7:0];
      6'd29: b = BYTE_RATE_W[15:8];
      6'd30: b = BYTE_RATE_W[23:16];
      6'd31: b = BYTE_RATE_W[31:24];
      6'd32: b = BLOCK_ALIGN;
      6'd34: b = BITS_SMPL;
      6'd36: b = 8'h64;
      6'd37: b = 8'h61;
      6'd38: b = 8'h74;
      6'd39: b = 8'h61;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Patch index 0..3 covers the RIFF size at offsets 4..7, 4..7 the data size at 40..43.
  function automatic logic [7:0] patch_byte(input logic [2:0] i, input logic [31:0] riff,
                                            input logic [31:0] data);
    logic [31:0] w;
    logic [7:0]  b;
    w = i[2] ? data : riff;
    case (i[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] patch_addr(input logic [15:0] base, input logic [2:0] i);
    return base + (i[2] ? 16'd40 : 16'd4) + {14'b0, i[1:0]};
  endfunction

  assign start_edge = I_START & ~start_prev_q;
  // The tail flag keeps the holding register busy while its last byte is on the bus.
  assign occupied   = hold_valid_q | hold_tail_q;
  assign room       = ({1'b0, len_q} + 17'(BYTES)) <= {1'b0, MAX_DATA};
  assign riff_size  = {16'b0, len_q} + 32'd36;
  assign data_size  = {16'b0, len_q};
  assign pnext      = idx_q[2:0] + 3'd1;

`ifndef WAVE_CAPTURE_16BIT_EN
  logic smpl_lo_unused;
  assign smpl_lo_unused = ^I_SMPL[7:0];
`endif

  always_comb begin
    state_d      = state_q;
    start_prev_d = I_START;
    base_d       = base_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_tail_d  = 1'b0;
    stop_seen_d  = stop_seen_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    len_d        = len_q;
    ovf_d        = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d      = S_HDR;
          base_d       = I_BASE_ADDR;
          idx_d        = '0;
          len_d        = '0;
          ovf_d        = 1'b0;
          hold_valid_d = 1'b0;
          stop_seen_d  = 1'b0;
          wr_en_d      = 1'b1;
          wr_addr_d    = I_BASE_ADDR;
          wr_data_d    = hdr_byte(6'd0);
        end
      end

      // idx_q is the header offset currently on the write bus.
      S_HDR: begin
        if (idx_q == HDR_LAST) begin
          state_d = S_DATA;
        end else begin
          idx_d     = idx_q + 6'd1;
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + {10'b0, idx_q} + 16'd1;
          wr_data_d = hdr_byte(idx_q + 6'd1);
        end
      end

      S_DATA: begin
        stop_seen_d = stop_seen_q | I_STOP;
        if (I_SMPL_STB && occupied) ovf_d = 1'b1;
        if (hold_valid_q) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = base_q + DATA_OFS + len_q;
          wr_data_d    = hold_q;
          len_d        = len_q + 16'd1;
          hold_valid_d = 1'b0;
          hold_tail_d  = 1'b1;
        end else if (I_SMPL_STB && !occupied && !stop_seen_q && room) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + DATA_OFS + len_q;
          len_d     = len_q + 16'd1;
`ifdef WAVE_CAPTURE_16BIT_EN
          wr_data_d    = I_SMPL[7:0];
          hold_d       = I_SMPL[15:8];
          hold_valid_d = 1'b1;
`else
          wr_data_d = I_SMPL[15:8] ^ 8'h80;
`endif
        end else if (stop_seen_q || I_STOP || !room) begin
          state_d   = S_PATCH;
          idx_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = patch_addr(base_q, 3'd0);
          wr_data_d = patch_byte(3'd0, riff_size, data_size);
        end
      end

      S_PATCH: begin
        if (idx_q[2:0] == 3'd7) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d     = {3'b0, pnext};
          wr_en_d   = 1'b1;
          wr_addr_d = patch_addr(base_q, pnext);
          wr_data_d = patch_byte(pnext, riff_size, data_size);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      base_q       <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_tail_q  <= 1'b0;
      stop_seen_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_tail_q  <= hold_tail_d;
      stop_seen_q  <= stop_seen_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
    end
  end

  assign O_WR_EN   = wr_en_q;
  assign O_WR_ADDR = wr_addr_q;
  assign O_WR_DATA = wr_data_q;
  assign O_BUSY    = busy_q;
  assign O_DONE    = done_q;
  assign O_LEN     = len_q;
  assign O_OVF     = ovf_q;

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed vectors for wave_capture covering header, data, patch,
// overflow, size limit with address wrap, and reset/re-trigger behaviour.
`timescale 1ns/1ps
module tb_wave_capture;

`ifdef WAVE_CAPTURE_16BIT_EN
  localparam int unsigned BYTES = 2;
  localparam int unsigned NS    = 2;
  localparam int unsigned GAP   = 5;
  logic [15:0] smp  [NS]      = '{16'h1234, 16'hABCD};
  logic [7:0]  expb [NS*BYTES] = '{8'h34, 8'h12, 8'hCD, 8'hAB};
`else
  localparam int unsigned BYTES = 1;
  localparam int unsigned NS    = 3;
  localparam int unsigned GAP   = 3;
  logic [15:0] smp  [NS]      = '{16'h7FFF, 16'h0000, 16'h8000};
  logic [7:0]  expb [NS*BYTES] = '{8'hFF, 8'h80, 8'h00};
`endif
  localparam int unsigned NB = NS * BYTES;

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        stb   = 1'b0;
  logic [15:0] base  = '0;
  logic [15:0] smpl  = '0;

  logic [15:0] wr_addr, lim_addr;
  logic [7:0]  wr_data, lim_data;
  logic        wr_en, busy, done, ovf;
  logic        lim_wen, lim_busy, lim_done, lim_ovf;
  logic [15:0] len, lim_len;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  wr_t         log_q [$];
  logic [7:0]  mem     [logic [15:0]];
  logic [7:0]  lim_mem [logic [15:0]];
  int unsigned done_cnt = 0, done_cyc = 0, lim_cnt = 0, lim_done_cnt = 0;
  logic        busy_at_done = 1'b0;

  wave_capture dut (
    .I_CLK(clk), .I_RSTn(rst_n), .I_START(start), .I_STOP(stop),
    .I_BASE_ADDR(base), .I_SMPL_STB(stb), .I_SMPL(smpl),
    .O_WR_ADDR(wr_addr), .O_WR_DATA(wr_data), .O_WR_EN(wr_en),
    .O_BUSY(busy), .O_DONE(done), .O_LEN(len), .O_OVF(ovf)
  );

  wave_capture #(.MAX_DATA(16'd4)) dut_lim (
    .I_CLK(clk), .I_RSTn(rst_n), .I_START(start), .I_STOP(stop),
    .I_BASE_ADDR(base), .I_SMPL_STB(stb), .I_SMPL(smpl),
    .O_WR_ADDR(lim_addr), .O_WR_DATA(lim_data), .O_WR_EN(lim_wen),
    .O_BUSY(lim_busy), .O_DONE(lim_done), .O_LEN(lim_len), .O_OVF(lim_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      log_q.push_back('{cyc, wr_addr, wr_data});
      mem[wr_addr] = wr_data;
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (lim_wen) begin
      lim_mem[lim_addr] = lim_data;
      lim_cnt++;
    end
    if (lim_done) lim_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while (busy && n < 100) begin
      tick(1);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] rd32(input logic [15:0] a);
    return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
  endfunction

  function automatic int unsigned lcyc(input int unsigned i);
    return (i < log_q.size()) ? log_q[i].cyc : 0;
  endfunction

  function automatic logic [31:0] laddr(input int unsigned i);
    return (i < log_q.size()) ? {16'b0, log_q[i].addr} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned i0, c0, ts0, cs, d0, l0, ld0, bad_a;

    // reset state
    tick(3);
    check("rst_wen",  32'(wr_en), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_len",  32'(len), 32'd0);
    check("rst_ovf",  32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // capture A: header, data bytes, stop and patch at base 0x1000
    base = 16'h1000;
    i0 = log_q.size();
    d0 = done_cnt;
    start = 1'b1;
    c0 = cyc;
    tick(1);
    start = 1'b0;
    check("busy_c1", 32'(busy), 32'd1);
    check("addr_c1", 32'(wr_addr), 32'h1000);
    tick(44);
    check("hdr_cnt", log_q.size() - i0, 32'd44);
    check("hdr_first_cyc", lcyc(i0) - c0, 32'd1);
    check("hdr_last_cyc", lcyc(i0 + 43) - c0, 32'd44);
    bad_a = 0;
    for (int unsigned k = 0; k < 44; k++)
      if (laddr(i0 + k) != 32'h1000 + k) bad_a++;
    check("hdr_addr_seq", bad_a, 32'd0);
    check("hdr_riff", rd32(16'h1000), 32'h4646_4952);
    check("hdr_fmtlen", rd32(16'h1010), 32'h0000_0010);
    check("hdr_rate", rd32(16'h1018), 32'h0000_2B11);
    check("hdr_brate", rd32(16'h101C), (BYTES == 2) ? 32'h0000_5622 : 32'h0000_2B11);
    check("hdr_bits", 32'(mem[16'h1022]), (BYTES == 2) ? 32'h10 : 32'h08);
    check("hdr_dsize0", rd32(16'h1028), 32'd0);

    ts0 = 0;
    for (int unsigned k = 0; k < NS; k++) begin
      smpl = smp[k];
      stb  = 1'b1;
      if (k == 0) ts0 = cyc;
      tick(1);
      stb = 1'b0;
      tick(GAP - 1);
    end
    tick(2);
    check("data_first_cyc", lcyc(i0 + 44) - ts0, 32'd1);
`ifdef WAVE_CAPTURE_16BIT_EN
    check("data_second_cyc", lcyc(i0 + 45) - ts0, 32'd2);
`endif
    for (int unsigned k = 0; k < NB; k++)
      check("data_byte", 32'(mem[16'h102C + 16'(k)]), 32'(expb[k]));
    check("data_ovf", 32'(ovf), 32'd0);

    stop = 1'b1;
    cs = cyc;
    tick(1);
    stop = 1'b0;
    wait_idle("tmo_a");
    check("patch_first_cyc", lcyc(i0 + 44 + NB) - cs, 32'd1);
    check("patch_riff", rd32(16'h1004), NB + 36);
    check("patch_data", rd32(16'h1028), NB);
    check("len_a", 32'(len), NB);
    check("done_once", done_cnt - d0, 32'd1);
    check("done_cyc", done_cyc - lcyc(log_q.size() - 1), 32'd1);
    check("busy_at_done", 32'(busy_at_done), 32'd0);
    check("wr_total_a", log_q.size() - i0, 44 + NB + 8);

    // capture B: strobes on consecutive cycles
    base = 16'h3000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(44);
    smpl = 16'h1111;
    stb  = 1'b1;
    tick(1);
    smpl = 16'h2222;
    tick(1);
    stb = 1'b0;
    tick(3);
    check("ovf_b", 32'(ovf), 32'(BYTES == 2));
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_idle("tmo_b");
    check("len_b", 32'(len), 32'd2);
    check("b_byte0", 32'(mem[16'h302C]), (BYTES == 2) ? 32'h11 : 32'h91);
    check("b_byte1", 32'(mem[16'h302D]), (BYTES == 2) ? 32'h11 : 32'hA2);

    // capture C: MAX_DATA=4 instance at base 0xFFF0, six strobes, no stop
    base = 16'hFFF0;
    l0  = lim_cnt;
    ld0 = lim_done_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    tick(44);
    for (int unsigned k = 0; k < 6; k++) begin
      smpl = 16'((k + 1) * 32'h1111);
      stb  = 1'b1;
      tick(1);
      stb = 1'b0;
      tick(2);
    end
    for (int unsigned n = 0; n < 40 && lim_busy; n++) tick(1);
    check("lim_busy", 32'(lim_busy), 32'd0);
    check("lim_done", lim_done_cnt - ld0, 32'd1);
    check("lim_wr_cnt", lim_cnt - l0, 32'd56);
    check("lim_wrap16", 32'(lim_mem[16'h0000]), 32'h10);
    check("lim_len", 32'(lim_len), 32'd4);
    check("lim_riff", {lim_mem[16'hFFF7], lim_mem[16'hFFF6], lim_mem[16'hFFF5], lim_mem[16'hFFF4]},
          32'h28);
    check("lim_last", 32'(lim_mem[16'h001F]), (BYTES == 2) ? 32'h22 : 32'hC4);
    check("lim_no_extra", 32'(lim_mem.exists(16'h0020)), 32'd0);
    check("lim_ovf", 32'(lim_ovf), 32'd0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_idle("tmo_c");
    check("len_c", 32'(len), 32'(6 * BYTES));

    // capture D: reset during header, restart, ignored start edge in DATA
    base = 16'h2000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    check("hdr20_addr", laddr(log_q.size() - 1), 32'h2014);
    rst_n = 1'b0;
    #1;
    check("arst_wen", 32'(wr_en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(wr_addr), 32'd0);
    check("arst_data", 32'(wr_data), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    i0 = log_q.size();
    start = 1'b1;
    c0 = cyc;
    tick(1);
    start = 1'b0;
    check("re_addr", laddr(i0), 32'h2000);
    check("re_data", 32'(wr_data), 32'h52);
    check("re_cyc", lcyc(i0) - c0, 32'd1);
    tick(44);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("retrig_cnt", log_q.size() - i0, 32'd44);
    check("retrig_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_idle("tmo_d");
    check("d_riff", rd32(16'h2004), 32'd36);
    check("d_len", 32'(len), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
